// File: rtl/cam_pixel_tx.sv
// Camera stand-in: derives pclk, vsync, href and RGB565 bytes from clk_in, one pixel per ready/valid transfer.
// Define CAM_TX_PATTERN_EN to add an 8-bar colour pattern source selected by pattern_in at frame start.
module cam_pixel_tx #(
  parameter int CLK_DIV     = 4,
  parameter int H_ACTIVE    = 320,
  parameter int H_BLANK     = 144,
  parameter int V_ACTIVE    = 240,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [15:0] pixel_in,
  input  logic        pixel_valid_in,
  output logic        pixel_ready_out,
  input  logic        pattern_in,
  output logic        pclk_out,
  output logic        vsync_out,
  output logic        href_out,
  output logic [7:0]  data_out,
  output logic        frame_start_out,
  output logic        underrun_out
);

  localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
  localparam int COL_W    = $clog2(LINE_LEN);
  localparam int DIV_W    = $clog2(CLK_DIV);
  localparam int V_MAX_A  = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int V_MAX_B  = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int V_MAX    = (V_MAX_A > V_MAX_B) ? V_MAX_A : V_MAX_B;
  localparam int LN_W     = (V_MAX > 1) ? $clog2(V_MAX) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(CLK_DIV - 2);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2 - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_LEN - 1);
  localparam logic [COL_W-1:0] COL_ACT  = COL_W'(2 * H_ACTIVE);
  localparam logic [LN_W-1:0]  VS_LAST  = LN_W'(VSYNC_LINES - 1);
  localparam logic [LN_W-1:0]  VB_LAST  = LN_W'(V_BACK - 1);
  localparam logic [LN_W-1:0]  VA_LAST  = LN_W'(V_ACTIVE - 1);
  localparam logic [LN_W-1:0]  VF_LAST  = LN_W'(V_FRONT - 1);

  typedef enum logic [1:0] {VSYNC, VBACK, ACTIVE, VFRONT} vstate_t;

  vstate_t           state, state_nxt;
  logic [LN_W-1:0]   line_cnt, line_nxt;
  logic [COL_W-1:0]  col_cnt, col_nxt;
  logic [DIV_W-1:0]  div_cnt;
  logic              started;
  logic [15:0]       pix_hold;
  logic              tick, pre_tick, half;
  logic              line_last, in_active, first_byte, frame_first;
  logic              pat_on;
  logic [15:0]       pat_pix;

  assign tick     = (div_cnt == DIV_LAST);
  assign pre_tick = (div_cnt == DIV_PRE);
  assign half     = (div_cnt == DIV_HALF);

  // Counters name the position that the next tick will put on the bus.
  assign in_active   = (state == ACTIVE) && (col_cnt < COL_ACT);
  assign first_byte  = in_active && !col_cnt[0];
  assign frame_first = (state == VSYNC) && (line_cnt == '0) && (col_cnt == '0);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state    <= VSYNC;
      line_cnt <= '0;
      col_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      line_cnt <= line_nxt;
      col_cnt  <= col_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    line_nxt  = line_cnt;
    col_nxt   = col_cnt;
    line_last = 1'b0;
    case (state)
      VSYNC:   line_last = (line_cnt == VS_LAST);
      VBACK:   line_last = (line_cnt == VB_LAST);
      ACTIVE:  line_last = (line_cnt == VA_LAST);
      default: line_last = (line_cnt == VF_LAST);
    endcase
    if (tick) begin
      if (col_cnt == COL_LAST) begin
        col_nxt = '0;
        if (line_last) begin
          line_nxt = '0;
          case (state)
            VSYNC:   state_nxt = VBACK;
            VBACK:   state_nxt = ACTIVE;
            ACTIVE:  state_nxt = VFRONT;
            default: state_nxt = VSYNC;
          endcase
        end else begin
          line_nxt = line_cnt + 1'b1;
        end
      end else begin
        col_nxt = col_cnt + 1'b1;
      end
    end
  end

`ifdef CAM_TX_PATTERN_EN
  localparam int BAR_PX = H_ACTIVE / 8;
  localparam int BAR_W  = (BAR_PX > 1) ? $clog2(BAR_PX) : 1;
  localparam logic [BAR_W-1:0] BAR_LAST = BAR_W'(BAR_PX - 1);

  logic             pat_mode;
  logic [BAR_W-1:0] bar_px;
  logic [2:0]       bar_idx;

  // Bar position advances after each low byte and wraps back to bar 0 exactly at the end of href.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pat_mode <= 1'b0;
      bar_px   <= '0;
      bar_idx  <= '0;
    end else if (tick) begin
      if (frame_first) pat_mode <= pattern_in;
      if (in_active && col_cnt[0]) begin
        if (bar_px == BAR_LAST) begin
          bar_px  <= '0;
          bar_idx <= bar_idx + 3'd1;
        end else begin
          bar_px <= bar_px + 1'b1;
        end
      end
    end
  end

  always_comb begin
    pat_pix = 16'h0000;
    case (bar_idx)
      3'd0:    pat_pix = 16'hFFFF;
      3'd1:    pat_pix = 16'hFFE0;
      3'd2:    pat_pix = 16'h07FF;
      3'd3:    pat_pix = 16'h07E0;
      3'd4:    pat_pix = 16'hF81F;
      3'd5:    pat_pix = 16'hF800;
      3'd6:    pat_pix = 16'h001F;
      default: pat_pix = 16'h0000;
    endcase
  end

  assign pat_on = pat_mode;
`else
  logic unused_pattern;
  assign unused_pattern = pattern_in;
  assign pat_on         = 1'b0;
  assign pat_pix        = 16'h0000;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      div_cnt         <= '0;
      started         <= 1'b0;
      pclk_out        <= 1'b0;
      vsync_out       <= 1'b0;
      href_out        <= 1'b0;
      data_out        <= 8'h00;
      pixel_ready_out <= 1'b0;
      frame_start_out <= 1'b0;
      underrun_out    <= 1'b0;
      pix_hold        <= 16'h0000;
    end else begin
      frame_start_out <= 1'b0;
      underrun_out    <= 1'b0;
      pixel_ready_out <= pre_tick && first_byte && !pat_on;
      if (tick) begin
        div_cnt         <= '0;
        started         <= 1'b1;
        pclk_out        <= 1'b0;
        vsync_out       <= (state == VSYNC);
        href_out        <= in_active;
        frame_start_out <= frame_first;
        if (first_byte) begin
          if (pat_on) begin
            data_out <= pat_pix[15:8];
            pix_hold <= pat_pix;
          end else if (pixel_ready_out && pixel_valid_in) begin
            data_out <= pixel_in[15:8];
            pix_hold <= pixel_in;
          end else begin
            data_out     <= 8'h00;
            pix_hold     <= 16'h0000;
            underrun_out <= 1'b1;
          end
        end else if (in_active) begin
          data_out <= pix_hold[7:0];
        end else begin
          data_out <= 8'h00;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
        // Hold pclk low until the first frame has begun so its first rise follows vsync.
        if (half && started) pclk_out <= 1'b1;
      end
    end
  end

endmodule
